stream_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready output channel among NUM_REQ upstream producers, with packet locking on a last flag. The output channel is isolated by an internal skid buffer, so there is no combinational path from ready_out to any ready_in. It sits in front of any single-consumer stage that several streams must reach, such as a shared bus port or an output FIFO.

---
 rtl/stream_pkg.sv | 35 +++
 rtl/skidbuffer.sv | 67 ++++++
 rtl/stream_rr_arbiter.sv | 100 ++++++++++
 tb/tb_stream_rr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for stream blocks: arbiter FSM encoding and round-robin search.
// rr_pick has no state of its own; all latency and backpressure come from the caller.
package stream_pkg;

  localparam int RR_MAX_REQ = 16;
  localparam int RR_IDX_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Unused requester slots must be zero, so a 16-wide wrap gives the same
  // answer as a wrap modulo the real requester count.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input logic [RR_IDX_W-1:0]   ptr);
    rr_pick_t            res;
    logic [RR_IDX_W-1:0] idx;
    res = '0;
    for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
      idx = ptr + RR_IDX_W'(k);
      if (valid[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/skidbuffer.sv
// Two-entry valid/ready skid buffer; the output is registered, so an accepted beat shows on the next edge.
// ready_in comes only from the skid-entry flag and is forced low during reset.
module skidbuffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic                  main_vld_q, main_vld_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] main_dat_q, main_dat_d;
  logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic                  in_fire;
  logic                  main_free;

  assign ready_in  = !skid_vld_q && !reset;
  assign in_fire   = valid_in && ready_in;
  assign main_free = !main_vld_q || ready_out;

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (main_free) begin
      // A full skid entry means ready_in is low, so no input beat competes here.
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_vld_d = 1'b1;
        main_dat_d = data_in;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_dat_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_dat_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_dat_q <= main_dat_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign valid_out = main_vld_q;
  assign data_out  = main_dat_q;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter with packet locking on last, feeding one stream through a skid buffer (1-cycle latency).
// Backpressure: ready_in depends only on the registered skid state, never combinationally on ready_out.
module stream_rr_arbiter
  import stream_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            valid_in,
  output logic [NUM_REQ-1:0]            ready_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_REQ-1:0]            last_in,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          last_out,
  output logic [ID_WIDTH-1:0]           grant_id
);

  localparam int SB_WIDTH = ID_WIDTH + 1 + DATA_WIDTH;

  arb_state_t            state_q;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [ID_WIDTH-1:0]   grant_q;
  logic [ID_WIDTH-1:0]   pick;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  pick_ok;
  logic                  pick_last;
  logic [DATA_WIDTH-1:0] pick_dat;
  logic [RR_MAX_REQ-1:0] valid_ext;
  rr_pick_t              rr_res;
  logic                  sb_valid_in;
  logic                  sb_ready_in;
  logic                  sb_fire;
  logic [SB_WIDTH-1:0]   sb_data_in;
  logic [SB_WIDTH-1:0]   sb_data_out;

  assign valid_ext = RR_MAX_REQ'(valid_in);
  assign rr_res    = rr_pick(valid_ext, RR_IDX_W'(rr_ptr_q));

  // A locked packet keeps its owner even while that owner's valid is low.
  always_comb begin
    if (state_q == ST_BUSY) begin
      pick    = grant_q;
      pick_ok = 1'b1;
    end else begin
      pick    = ID_WIDTH'(rr_res.idx);
      pick_ok = rr_res.found;
    end
  end

  assign pick_dat    = data_in[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
  assign pick_last   = last_in[pick];
  assign sb_valid_in = pick_ok && valid_in[pick];
  assign sb_fire     = sb_valid_in && sb_ready_in;
  assign sb_data_in  = {pick, pick_last, pick_dat};
  assign next_ptr    = (pick == ID_WIDTH'(NUM_REQ - 1)) ? '0 : pick + ID_WIDTH'(1);

  always_comb begin
    ready_in = '0;
    if (sb_ready_in && pick_ok && (state_q == ST_BUSY || valid_in[pick])) begin
      ready_in[pick] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else if (sb_fire) begin
      if (pick_last) begin
        state_q  <= ST_IDLE;
        rr_ptr_q <= next_ptr;
      end else if (state_q == ST_IDLE) begin
        state_q <= ST_BUSY;
        grant_q <= pick;
      end
    end
  end

  skidbuffer #(
    .DATA_WIDTH(SB_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .valid_in (sb_valid_in),
    .ready_in (sb_ready_in),
    .data_in  (sb_data_in),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .data_out (sb_data_out)
  );

  assign {grant_id, last_out, data_out} = sb_data_out;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed packet tables per requester, a queue-level model checked every cycle.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  valid_in, ready_in, last_in;
  logic [N*DW-1:0] data_in;
  logic          valid_out, ready_out, last_out;
  logic [DW-1:0] data_out;
  logic [1:0]    grant_id;

  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .data_in  (data_in),
    .last_in  (last_in),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .data_out (data_out),
    .last_out (last_out),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; logic l; int gap;} src_beat_t;
  typedef struct {int id; logic [7:0] d; logic l;} out_beat_t;

  src_beat_t srcq[N][$];
  int        gapc[N];
  int        present_cyc[N];
  int        acc_wait[N][$];
  logic [N-1:0] acc;
  out_beat_t outlog[$];
  int        outcyc[$];
  out_beat_t exp_log[$];
  out_beat_t mq[$];
  bit        m_busy;
  int        m_owner, m_ptr;
  int        cyc, errors, checks;
  bit        mon_en, bp_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_beat(input int r, input int d, input bit l, input int gap);
    src_beat_t b;
    b.d = 8'(d); b.l = l; b.gap = gap;
    if (srcq[r].size() == 0 && !valid_in[r]) gapc[r] = gap;
    srcq[r].push_back(b);
  endtask

  task automatic add_exp(input int id, input int d, input bit l);
    out_beat_t b;
    b.id = id; b.d = 8'(d); b.l = l;
    exp_log.push_back(b);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (valid_in[i] && acc[i]) begin
        void'(srcq[i].pop_front());
        acc_wait[i].push_back(cyc - 1 - present_cyc[i]);
        valid_in[i] = 1'b0;
        gapc[i] = (srcq[i].size() > 0) ? srcq[i][0].gap : 0;
      end
      if (!valid_in[i] && srcq[i].size() > 0) begin
        if (gapc[i] > 0) gapc[i]--;
        else begin
          valid_in[i] = 1'b1;
          data_in[i*DW +: DW] = srcq[i][0].d;
          last_in[i] = srcq[i][0].l;
          present_cyc[i] = cyc;
        end
      end
    end
    ready_out = bp_en ? ((cyc % 7) < 4) : 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  function automatic bit sources_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    outlog.delete(); outcyc.delete();
    for (int i = 0; i < N; i++) acc_wait[i].delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; bp_en = 1'b0;
    for (int i = 0; i < N; i++) begin srcq[i].delete(); gapc[i] = 0; end
    valid_in = '0; last_in = '0; data_in = '0;
    repeat (n) cycle();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic run_idle(input int budget, input string name);
    int n = 0;
    while (!(sources_empty() && valid_in == '0 && !valid_out) && n < budget) begin
      cycle(); n++;
    end
    chk({name, " drained within budget"}, 32'(n < budget), 1);
  endtask

  task automatic check_log(input string name);
    chk({name, " beat count"}, outlog.size(), exp_log.size());
    for (int k = 0; k < exp_log.size() && k < outlog.size(); k++) begin
      chk($sformatf("%s beat%0d id", name, k), outlog[k].id, exp_log[k].id);
      chk($sformatf("%s beat%0d data", name, k), outlog[k].d, exp_log[k].d);
      chk($sformatf("%s beat%0d last", name, k), outlog[k].l, exp_log[k].l);
    end
    exp_log.delete();
  endtask

  function automatic int count_gaps();
    int g = 0;
    for (int k = 1; k < outcyc.size(); k++) if (outcyc[k] - outcyc[k-1] != 1) g++;
    return g;
  endfunction

  // Model: an arbiter feeding a two-beat holding queue; ready only while fewer than two beats are held.
  always @(negedge clk) begin
    int p; bit ok; logic [N-1:0] er; out_beat_t b;
    acc = valid_in & ready_in;
    ok = 1'b0; p = 0;
    if (m_busy) begin ok = 1'b1; p = m_owner; end
    else for (int k = N - 1; k >= 0; k--)
      if (valid_in[(m_ptr + k) % N]) begin ok = 1'b1; p = (m_ptr + k) % N; end
    er = '0;
    if (!reset && mq.size() < 2 && ok && (m_busy || valid_in[p])) er[p] = 1'b1;
    if (mon_en) begin
      chk("cycle ready_in", ready_in, er);
      chk("cycle valid_out", valid_out, 32'(mq.size() > 0));
      if (valid_out && mq.size() > 0) begin
        chk("cycle grant_id", grant_id, mq[0].id);
        chk("cycle data_out", data_out, mq[0].d);
        chk("cycle last_out", last_out, mq[0].l);
      end
    end
    if (valid_out && ready_out) begin
      b.id = grant_id; b.d = data_out; b.l = last_out;
      outlog.push_back(b); outcyc.push_back(cyc);
    end
    if (reset) begin
      mq.delete(); m_busy = 1'b0; m_ptr = 0; m_owner = 0;
    end else begin
      if (mq.size() > 0 && ready_out) void'(mq.pop_front());
      if (er[p] && valid_in[p]) begin
        b.id = p; b.d = data_in[p*DW +: DW]; b.l = last_in[p];
        mq.push_back(b);
        if (last_in[p]) begin m_busy = 1'b0; m_ptr = (p + 1) % N; end
        else if (!m_busy) begin m_busy = 1'b1; m_owner = p; end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; valid_in = '1; last_in = '0; data_in = '0; ready_out = 1'b1;
    acc = '0; cyc = 0; errors = 0; checks = 0; mon_en = 1'b0; bp_en = 1'b0;
    m_busy = 1'b0; m_ptr = 0; m_owner = 0;
    for (int i = 0; i < N; i++) begin gapc[i] = 0; present_cyc[i] = 0; end

    // Reset state, with every requester asserting valid.
    repeat (3) begin
      cycle();
      mon_en = 1'b1;
      chk("reset valid_out", valid_out, 0);
      chk("reset data_out", data_out, 0);
      chk("reset last_out", last_out, 0);
      chk("reset grant_id", grant_id, 0);
      chk("reset ready_in", ready_in, 0);
    end
    valid_in = '0;

    // Single requester, 20 single-beat packets.
    do_reset(2);
    for (int k = 0; k < 20; k++) begin add_beat(2, k, 1'b1, 0); add_exp(2, k, 1'b1); end
    cycle();
    cycle();
    chk("single first valid_out", valid_out, 1);
    chk("single first data_out", data_out, 0);
    chk("single first grant_id", grant_id, 2);
    run_idle(200, "single");
    check_log("single");
    chk("single output gaps", count_gaps(), 0);

    // Fair rotation among four always-valid requesters.
    do_reset(2);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) add_beat(i, i * 16 + k, 1'b1, 0);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) add_exp(i, i * 16 + k, 1'b1);
    run_idle(200, "rotate");
    check_log("rotate");
    chk("rotate output gaps", count_gaps(), 0);

    // Packet lock across a valid gap.
    do_reset(2);
    add_beat(1, 'h10, 1'b0, 0); add_beat(1, 'h11, 1'b0, 0);
    add_beat(1, 'h12, 1'b0, 2); add_beat(1, 'h13, 1'b1, 0);
    add_beat(0, 'h00, 1'b0, 1); add_beat(0, 'h01, 1'b1, 0);
    add_exp(1, 'h10, 1'b0); add_exp(1, 'h11, 1'b0); add_exp(1, 'h12, 1'b0);
    add_exp(1, 'h13, 1'b1); add_exp(0, 'h00, 1'b0); add_exp(0, 'h01, 1'b1);
    run_idle(200, "lock");
    if (outcyc.size() >= 5) chk("lock r0 follows immediately", outcyc[4] - outcyc[3], 1);
    check_log("lock");

    // Backpressure: ready_out 4 high / 3 low.
    do_reset(2);
    bp_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      add_beat(0, k, 1'b1, 0); add_beat(3, 'h30 + k, 1'b1, 0);
      add_exp(0, k, 1'b1); add_exp(3, 'h30 + k, 1'b1);
    end
    run_idle(300, "backpressure");
    bp_en = 1'b0;
    check_log("backpressure");

    // Wrap: pointer at 3 after requester 2, then requester 0 alone, then 0 and 1 together.
    do_reset(2);
    add_beat(2, 'h20, 1'b1, 0);
    run_idle(50, "wrap a");
    add_beat(0, 'h00, 1'b0, 0); add_beat(0, 'h01, 1'b1, 0);
    run_idle(50, "wrap b");
    chk("wrap r0 accepted beats", acc_wait[0].size(), 2);
    if (acc_wait[0].size() > 0) chk("wrap r0 wait cycles", acc_wait[0][0], 0);
    add_beat(0, 'h02, 1'b1, 0); add_beat(1, 'h11, 1'b1, 0);
    run_idle(50, "wrap c");
    add_exp(2, 'h20, 1'b1); add_exp(0, 'h00, 1'b0); add_exp(0, 'h01, 1'b1);
    add_exp(1, 'h11, 1'b1); add_exp(0, 'h02, 1'b1);
    check_log("wrap");

    // Reset in the middle of a 5-beat packet.
    do_reset(2);
    for (int k = 0; k < 5; k++) add_beat(1, 'h50 + k, 1'(k == 4), 0);
    n = 0;
    while (acc_wait[1].size() < 2 && n < 50) begin cycle(); n++; end
    chk("midreset two beats accepted", 32'(n < 50), 1);
    reset = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    valid_in = '0;
    repeat (2) begin
      cycle();
      chk("midreset valid_out", valid_out, 0);
      chk("midreset data_out", data_out, 0);
      chk("midreset last_out", last_out, 0);
      chk("midreset grant_id", grant_id, 0);
      chk("midreset ready_in", ready_in, 0);
    end
    reset = 1'b0;
    clear_logs();
    add_beat(3, 'h60, 1'b0, 0); add_beat(3, 'h61, 1'b1, 0);
    add_exp(3, 'h60, 1'b0); add_exp(3, 'h61, 1'b1);
    run_idle(50, "midreset");
    chk("midreset r3 accepted beats", acc_wait[3].size(), 2);
    if (acc_wait[3].size() > 0) chk("midreset r3 wait cycles", acc_wait[3][0], 0);
    check_log("midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
